// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped peripheral block: register
// offsets within the 32-byte window, TCON bit positions and the default
// base address.
package peripheral_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets from the base address (word aligned).
  localparam logic [4:0] TH_OFF      = 5'h00;
  localparam logic [4:0] TL_OFF      = 5'h04;
  localparam logic [4:0] TCON_OFF    = 5'h08;
  localparam logic [4:0] LED_OFF     = 5'h0C;
  localparam logic [4:0] DIGI_OFF    = 5'h10;
  localparam logic [4:0] SYSTICK_OFF = 5'h14;

  // TCON bit indices.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/peripheral_if.sv
// MEM-stage data bus as seen by the peripheral block. The CPU side is the
// master; the peripheral decodes and answers as the slave.
interface peripheral_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Sel;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data, Sel
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data, Sel
  );

endinterface

// File: rtl/peripheral_unit_timer_core.sv
// Reloadable 32-bit timer: TH (reload), TL (counter) and TCON (EN/IE/IS).
// A bus write to TL suppresses that cycle's count step entirely, including
// any IS set; a bus write to TCON overrides an IS set by overflow.
module timer_core
  import peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  // Next-state: writes, count/reload step and sticky interrupt status.
  always_comb begin
    th_d   = wr_th ? wdata : th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_tl) begin
      tl_d = wdata;
    end else if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        // Reload uses the TH value held before this edge.
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_tcon) tcon_d = wdata[2:0];
  end

  // Timer state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/peripheral_unit.sv
// Memory-mapped peripheral block on the MEM-stage data bus: address decode,
// combinational read mux, LED and digit registers, timer instance and an
// optional free-running tick counter built when PERIPHERAL_SYSTICK_EN is
// defined (otherwise offset 0x14 reads 0 and ignores writes).
module peripheral_unit
  import peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  peripheral_if.slave         bus,
  output logic                IRQ,
  output logic [7:0]          led,
  output logic [11:0]         digi
);

  logic        sel;
  logic        wr;
  logic [4:0]  off;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign sel             = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign wr              = bus.MemWrite & sel;
  assign off             = {bus.Address[4:2], 2'b00};
  assign unused_addr_lsb = ^bus.Address[1:0];

  timer_core u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr && (off == TH_OFF)),
    .wr_tl   (wr && (off == TL_OFF)),
    .wr_tcon (wr && (off == TCON_OFF)),
    .wdata   (bus.Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (IRQ)
  );

  // LED and digit register write ports.
  always_comb begin
    led_d  = (wr && (off == LED_OFF))  ? bus.Write_data[7:0]  : led_q;
    digi_d = (wr && (off == DIGI_OFF)) ? bus.Write_data[11:0] : digi_q;
  end

  // LED and digit registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

`ifdef PERIPHERAL_SYSTICK_EN
  logic [31:0] tick_q, tick_d;

  // Free-running tick: a bus write loads, otherwise increment with wrap.
  always_comb begin
    tick_d = (wr && (off == SYSTICK_OFF)) ? bus.Write_data : tick_q + 32'd1;
  end

  // Tick counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end
`endif

  // Read mux: zero unless a read hits the window.
  always_comb begin
    rdata = '0;
    if (bus.MemRead && sel) begin
      case (off)
        TH_OFF:      rdata = th;
        TL_OFF:      rdata = tl;
        TCON_OFF:    rdata = {29'd0, tcon};
        LED_OFF:     rdata = {24'd0, led_q};
        DIGI_OFF:    rdata = {20'd0, digi_q};
`ifdef PERIPHERAL_SYSTICK_EN
        SYSTICK_OFF: rdata = tick_q;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = rdata;
  assign bus.Sel       = sel;
  assign led           = led_q;
  assign digi          = digi_q;

endmodule

// File: tb/tb_peripheral_unit.sv
// Directed bench for peripheral_unit with a register-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_peripheral_unit;
  import peripheral_pkg::*;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRQ;
  logic [7:0]  led;
  logic [11:0] digi;

  peripheral_if bus ();

  peripheral_unit #(.BASE_ADDR(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (IRQ),
    .led   (led),
    .digi  (digi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] tick;
    logic        en;
    logic        ie;
    logic        is;
    logic [7:0]  led;
    logic [11:0] digi;
  } mstate_t;

  mstate_t m;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= B) && (a < B + 32'd32);
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic we,
                                   input logic [31:0] a, input logic [31:0] wd);
    mstate_t n;
    logic [32:0] inc;
    int w;
    n = s;
    if (s.en) begin
      inc = {1'b0, s.tl} + 33'd1;
      if (inc[32]) begin
        n.tl = s.th;
        n.is = s.is | s.ie;
      end else begin
        n.tl = inc[31:0];
      end
    end
`ifdef PERIPHERAL_SYSTICK_EN
    n.tick = s.tick + 32'd1;
`endif
    if (we && in_win(a)) begin
      w = int'((a - B) >> 2);
      case (w)
        0: n.th = wd;
        1: begin n.tl = wd; n.is = s.is; end
        2: begin n.en = wd[0]; n.ie = wd[1]; n.is = wd[2]; end
        3: n.led = wd[7:0];
        4: n.digi = wd[11:0];
`ifdef PERIPHERAL_SYSTICK_EN
        5: n.tick = wd;
`endif
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(input mstate_t s, input logic r, input logic [31:0] a);
    int w;
    if (!(r && in_win(a))) return 32'd0;
    w = int'((a - B) >> 2);
    case (w)
      0: return s.th;
      1: return s.tl;
      2: return {29'd0, s.is, s.ie, s.en};
      3: return {24'd0, s.led};
      4: return {20'd0, s.digi};
`ifdef PERIPHERAL_SYSTICK_EN
      5: return s.tick;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, bus.MemWrite, bus.Address, bus.Write_data);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_sel",   {31'd0, bus.Sel}, {31'd0, in_win(bus.Address)});
    chk("m_rdata", bus.Read_data, mread(m, bus.MemRead, bus.Address));
    chk("m_irq",   {31'd0, IRQ}, {31'd0, m.ie & m.is});
    chk("m_led",   {24'd0, led}, {24'd0, m.led});
    chk("m_digi",  {20'd0, digi}, {20'd0, m.digi});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b1;
    bus.Address    = B + {27'd0, o};
    bus.Write_data = d;
    tick();
    bus.MemWrite   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] o, input logic [31:0] exp, input string nm);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.Address  = B + {27'd0, o};
    #1;
    chk(nm, bus.Read_data, exp);
  endtask

  initial begin
    reset          = 1'b1;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Address    = 32'd0;
    bus.Write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_idle_rdata", bus.Read_data, 32'd0);
    rd(TH_OFF, 32'd0, "rst_th");
    #2 reset = 1'b0;
    tick();

    // reload with interrupt
    wr(TH_OFF, 32'hFFFF_FFFC);
    wr(TL_OFF, 32'hFFFF_FFFE);
    wr(TCON_OFF, 32'd3);
    rd(TL_OFF, 32'hFFFF_FFFE, "ld_tl0");
    chk("ld_irq0", {31'd0, IRQ}, 32'd0);
    tick();
    rd(TL_OFF, 32'hFFFF_FFFF, "ld_tl1");
    chk("ld_irq1", {31'd0, IRQ}, 32'd0);
    tick();
    rd(TL_OFF, 32'hFFFF_FFFC, "ld_tl_reload");
    chk("ld_irq_rise", {31'd0, IRQ}, 32'd1);
    rd(TCON_OFF, 32'd7, "ld_tcon_is");
    wr(TCON_OFF, 32'd3);
    chk("ld_irq_fall", {31'd0, IRQ}, 32'd0);

    // IE = 0: reload but no interrupt
    wr(TCON_OFF, 32'd0);
    wr(TH_OFF, 32'hFFFF_FFFC);
    wr(TL_OFF, 32'hFFFF_FFFE);
    wr(TCON_OFF, 32'd1);
    tick();
    rd(TL_OFF, 32'hFFFF_FFFF, "noie_tl1");
    tick();
    rd(TL_OFF, 32'hFFFF_FFFC, "noie_reload");
    rd(TCON_OFF, 32'd1, "noie_tcon");
    chk("noie_irq", {31'd0, IRQ}, 32'd0);

    // bus write to TL wins over reload
    wr(TCON_OFF, 32'd0);
    wr(TL_OFF, 32'hFFFF_FFFE);
    wr(TCON_OFF, 32'd3);
    tick();
    rd(TL_OFF, 32'hFFFF_FFFF, "col_tl_max");
    wr(TL_OFF, 32'd5);
    rd(TL_OFF, 32'd5, "col_tl5");
    rd(TCON_OFF, 32'd3, "col_tcon");
    chk("col_irq", {31'd0, IRQ}, 32'd0);
    tick();
    rd(TL_OFF, 32'd6, "col_tl6");

    // TH written in the overflow cycle: reload uses old TH
    wr(TCON_OFF, 32'd0);
    wr(TH_OFF, 32'd10);
    wr(TL_OFF, 32'hFFFF_FFFF);
    wr(TCON_OFF, 32'd1);
    wr(TH_OFF, 32'd20);
    rd(TL_OFF, 32'd10, "th_old_reload");
    rd(TH_OFF, 32'd20, "th_new");
    wr(TCON_OFF, 32'd0);

    // decode
    rd(5'h18, 32'd0, "rsvd18");
    wr(5'h18, 32'hDEAD_BEEF);
    rd(5'h1C, 32'd0, "rsvd1c");
    bus.MemRead = 1'b1;
    bus.Address = 32'h4000_1000;
    #1;
    chk("out_sel", {31'd0, bus.Sel}, 32'd0);
    chk("out_rdata", bus.Read_data, 32'd0);
    wr(LED_OFF, 32'h0000_01A5);
    chk("led_out", {24'd0, led}, 32'h0000_00A5);
    rd(LED_OFF, 32'h0000_00A5, "led_rd");
    wr(DIGI_OFF, 32'hFFFF_1234);
    chk("digi_out", {20'd0, digi}, 32'h0000_0234);
    rd(DIGI_OFF, 32'h0000_0234, "digi_rd");
    bus.MemWrite   = 1'b1;
    bus.Address    = 32'h4000_100C;
    bus.Write_data = 32'h0000_00FF;
    tick();
    bus.MemWrite   = 1'b0;
    chk("led_outside_wr", {24'd0, led}, 32'h0000_00A5);
    wr(TCON_OFF, 32'hFFFF_FFF8);
    rd(TCON_OFF, 32'd0, "tcon_upper");

    // systick
    wr(SYSTICK_OFF, 32'd100);
    bus.MemRead = 1'b0;
    repeat (3) tick();
`ifdef PERIPHERAL_SYSTICK_EN
    rd(SYSTICK_OFF, 32'd103, "systick");
`else
    rd(SYSTICK_OFF, 32'd0, "systick_absent");
`endif

    // software-set IS, then asynchronous reset mid-operation
    wr(TCON_OFF, 32'd6);
    chk("sw_irq", {31'd0, IRQ}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_irq", {31'd0, IRQ}, 32'd0);
    chk("arst_led", {24'd0, led}, 32'd0);
    chk("arst_digi", {20'd0, digi}, 32'd0);
    rd(TH_OFF, 32'd0, "arst_th");
    #1 reset = 1'b0;
    tick();
    rd(TCON_OFF, 32'd0, "post_rst_tcon");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
